// File: rtl/axil_csr_slave.sv
// AXI4-Lite CSR slave for the matrix core: CTRL/STATUS/DIM/SRC/DST/ID.
// Optional AXIL_CSR_IRQ_EN adds IRQ_EN at 0x18 and a registered irq_o.
module axil_csr_slave #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] ID_VALUE = 32'h4D41_5401
) (
  input  logic              ACLK,
  input  logic              ARST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              WVALID,
  output logic              WREADY,
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [1:0]        BRESP,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              start_o,
  input  logic              core_busy_i,
  input  logic              core_done_i,
  output logic [15:0]       dim_o,
  output logic [31:0]       src_addr_o,
  output logic [31:0]       dst_addr_o
`ifdef AXIL_CSR_IRQ_EN
  ,
  output logic              irq_o
`endif
);

  localparam int AW2 = ADDR_W - 2;
  localparam logic [AW2-1:0] IX_CTRL = AW2'(0);
  localparam logic [AW2-1:0] IX_STAT = AW2'(1);
  localparam logic [AW2-1:0] IX_DIM  = AW2'(2);
  localparam logic [AW2-1:0] IX_SRC  = AW2'(3);
  localparam logic [AW2-1:0] IX_DST  = AW2'(4);
  localparam logic [AW2-1:0] IX_ID   = AW2'(5);
`ifdef AXIL_CSR_IRQ_EN
  localparam logic [AW2-1:0] IX_IRQ  = AW2'(6);
`endif

  typedef enum logic [1:0] {
    WR_IDLE, WR_ADDR, WR_DATA, WR_RESP
  } wr_st_t;

  typedef enum logic {
    RD_IDLE, RD_DATA
  } rd_st_t;

  wr_st_t            wr_q, wr_d;
  rd_st_t            rd_q, rd_d;
  logic              rdy_q, rdy;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [3:0]        strb_q;
  logic              aw_lat, w_lat;
  logic              wr_commit;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_data;
  logic [3:0]        c_strb;
  logic [AW2-1:0]    widx, ridx;
  logic              w_ok, r_ok;
  logic [1:0]        bresp_q;
  logic [31:0]       rdata_q, rmux;
  logic [1:0]        rresp_q;
  logic              start_q, done_q;
  logic [15:0]       dim_q;
  logic [31:0]       src_q, dst_q;
  logic [31:0]       dim_new, src_new, dst_new;
  logic              start_ev, w1c;
  logic              ar_hs;
  logic              unused_addr_lsb;

  function automatic logic [31:0] merge(
    input logic [31:0] o,
    input logic [31:0] n,
    input logic [3:0]  s
  );
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i+:8] = n[8*i+:8];
    return r;
  endfunction

  assign unused_addr_lsb = &{1'b0, AWADDR[1:0], ARADDR[1:0]};

  // Hold READY low through reset and for the reset-release edge.
  always_ff @(posedge ACLK) begin
    if (ARST) rdy_q <= 1'b0;
    else      rdy_q <= 1'b1;
  end

  assign rdy = rdy_q & ~ARST;

  // Write state, latched AW/W halves.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      wr_q   <= WR_IDLE;
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
    end else begin
      wr_q <= wr_d;
      if (aw_lat) addr_q <= AWADDR;
      if (w_lat) begin
        data_q <= WDATA;
        strb_q <= WSTRB;
      end
    end
  end

  // Write next-state, channel readies and commit source select.
  always_comb begin
    wr_d      = wr_q;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    aw_lat    = 1'b0;
    w_lat     = 1'b0;
    wr_commit = 1'b0;
    c_addr    = AWADDR;
    c_data    = WDATA;
    c_strb    = WSTRB;
    unique case (wr_q)
      WR_IDLE: begin
        AWREADY = rdy;
        WREADY  = rdy;
        if (rdy && AWVALID && WVALID) begin
          wr_commit = 1'b1;
          wr_d      = WR_RESP;
        end else if (rdy && AWVALID) begin
          aw_lat = 1'b1;
          wr_d   = WR_ADDR;
        end else if (rdy && WVALID) begin
          w_lat = 1'b1;
          wr_d  = WR_DATA;
        end
      end
      WR_ADDR: begin
        WREADY = rdy;
        c_addr = addr_q;
        if (rdy && WVALID) begin
          wr_commit = 1'b1;
          wr_d      = WR_RESP;
        end
      end
      WR_DATA: begin
        AWREADY = rdy;
        c_data  = data_q;
        c_strb  = strb_q;
        if (rdy && AWVALID) begin
          wr_commit = 1'b1;
          wr_d      = WR_RESP;
        end
      end
      WR_RESP: begin
        if (BREADY) wr_d = WR_IDLE;
      end
      default: wr_d = WR_IDLE;
    endcase
  end

  assign widx     = c_addr[ADDR_W-1:2];
  assign dim_new  = merge({16'h0, dim_q}, c_data, c_strb);
  assign src_new  = merge(src_q, c_data, c_strb);
  assign dst_new  = merge(dst_q, c_data, c_strb);
  assign start_ev = wr_commit && widx == IX_CTRL &&
                    c_strb[0] && c_data[0] && !core_busy_i;
  assign w1c      = wr_commit && widx == IX_STAT &&
                    c_strb[0] && c_data[1];

  // Decode whether the write offset is mapped.
  always_comb begin
    w_ok = 1'b1;
    case (widx)
      IX_CTRL, IX_STAT, IX_DIM,
      IX_SRC, IX_DST, IX_ID: w_ok = 1'b1;
`ifdef AXIL_CSR_IRQ_EN
      IX_IRQ: w_ok = 1'b1;
`endif
      default: w_ok = 1'b0;
    endcase
  end

  // Register file update on the edge entering WR_RESP.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      bresp_q <= 2'b00;
      start_q <= 1'b0;
      dim_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
    end else begin
      start_q <= start_ev;
      if (wr_commit) begin
        bresp_q <= w_ok ? 2'b00 : 2'b10;
        if (widx == IX_DIM) dim_q <= dim_new[15:0];
        if (widx == IX_SRC) src_q <= src_new;
        if (widx == IX_DST) dst_q <= dst_new;
      end
    end
  end

  // Sticky DONE; a new done pulse beats a same-cycle clear.
  always_ff @(posedge ACLK) begin
    if (ARST) done_q <= 1'b0;
    else      done_q <= core_done_i | (done_q & ~w1c);
  end

`ifdef AXIL_CSR_IRQ_EN
  logic irq_en_q, irq_q;

  // Interrupt enable register and registered interrupt.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_commit && widx == IX_IRQ && c_strb[0])
        irq_en_q <= c_data[0];
      irq_q <= done_q & irq_en_q;
    end
  end

  assign irq_o = irq_q;
`endif

  assign ar_hs = ARVALID & ARREADY;
  assign ridx  = ARADDR[ADDR_W-1:2];

  // Read data mux over current register values.
  always_comb begin
    rmux = '0;
    r_ok = 1'b1;
    case (ridx)
      IX_CTRL: rmux = '0;
      IX_STAT: rmux = {30'h0, done_q, core_busy_i};
      IX_DIM:  rmux = {16'h0, dim_q};
      IX_SRC:  rmux = src_q;
      IX_DST:  rmux = dst_q;
      IX_ID:   rmux = ID_VALUE;
`ifdef AXIL_CSR_IRQ_EN
      IX_IRQ:  rmux = {31'h0, irq_en_q};
`endif
      default: r_ok = 1'b0;
    endcase
  end

  // Read state and registered response.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      rd_q    <= RD_IDLE;
      rdata_q <= '0;
      rresp_q <= 2'b00;
    end else begin
      rd_q <= rd_d;
      if (ar_hs) begin
        rdata_q <= rmux;
        rresp_q <= r_ok ? 2'b00 : 2'b10;
      end
    end
  end

  // Read next-state.
  always_comb begin
    rd_d = rd_q;
    unique case (rd_q)
      RD_IDLE: if (ar_hs)  rd_d = RD_DATA;
      RD_DATA: if (RREADY) rd_d = RD_IDLE;
      default: rd_d = RD_IDLE;
    endcase
  end

  assign ARREADY    = rdy & (rd_q == RD_IDLE);
  assign RVALID     = (rd_q == RD_DATA);
  assign RDATA      = rdata_q;
  assign RRESP      = rresp_q;
  assign BVALID     = (wr_q == WR_RESP);
  assign BRESP      = bresp_q;
  assign start_o    = start_q;
  assign dim_o      = dim_q;
  assign src_addr_o = src_q;
  assign dst_addr_o = dst_q;

endmodule

// File: tb/tb_axil_csr_slave.sv
// Randomized bench for axil_csr_slave against a register-map model.
// Define AXIL_CSR_IRQ_EN for both files to cover the IRQ option.
module tb_axil_csr_slave;

  logic        ACLK = 1'b0;
  logic        ARST = 1'b1;
  logic        AWVALID = 0, WVALID = 0, BREADY = 0;
  logic        ARVALID = 0, RREADY = 0;
  logic [7:0]  AWADDR = 0, ARADDR = 0;
  logic [31:0] WDATA = 0;
  logic [3:0]  WSTRB = 0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;
  logic        start_o;
  logic        core_busy_i = 0, core_done_i = 0;
  logic [15:0] dim_o;
  logic [31:0] src_addr_o, dst_addr_o;
`ifdef AXIL_CSR_IRQ_EN
  logic        irq_o;
`endif

  always #5 ACLK = ~ACLK;

  axil_csr_slave dut (
    .ACLK(ACLK), .ARST(ARST),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY),
    .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY),
    .RDATA(RDATA), .RRESP(RRESP),
    .start_o(start_o),
    .core_busy_i(core_busy_i), .core_done_i(core_done_i),
    .dim_o(dim_o), .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o)
`ifdef AXIL_CSR_IRQ_EN
    , .irq_o(irq_o)
`endif
  );

  int total = 0;
  int bad = 0;
  int start_cnt = 0;

  always @(posedge ACLK) if (start_o) start_cnt <= start_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: architectural register contents.
  logic [15:0] m_dim;
  logic [31:0] m_src, m_dst;
  logic        m_done, m_irqen;
  int          m_start;

  task automatic model_reset();
    m_dim = 0; m_src = 0; m_dst = 0; m_done = 0; m_irqen = 0;
  endtask

  function automatic bit mapped(input logic [7:0] a);
    logic [7:0] off;
    off = a & 8'hFC;
`ifdef AXIL_CSR_IRQ_EN
    return off <= 8'h18;
`else
    return off <= 8'h14;
`endif
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic busy);
    case (a & 8'hFC)
      8'h00: if (s[0] && d[0] && !busy) m_start++;
      8'h04: if (s[0] && d[1]) m_done = 0;
      8'h08: for (int i = 0; i < 2; i++)
               if (s[i]) m_dim[8*i+:8] = d[8*i+:8];
      8'h0C: for (int i = 0; i < 4; i++)
               if (s[i]) m_src[8*i+:8] = d[8*i+:8];
      8'h10: for (int i = 0; i < 4; i++)
               if (s[i]) m_dst[8*i+:8] = d[8*i+:8];
`ifdef AXIL_CSR_IRQ_EN
      8'h18: if (s[0]) m_irqen = d[0];
`endif
      default: ;
    endcase
  endtask

  task automatic model_read(input logic [7:0] a, input logic busy,
                            output logic [31:0] d, output logic [1:0] r);
    d = 0;
    r = mapped(a) ? 2'b00 : 2'b10;
    case (a & 8'hFC)
      8'h04: d = {30'h0, m_done, busy};
      8'h08: d = {16'h0, m_dim};
      8'h0C: d = m_src;
      8'h10: d = m_dst;
      8'h14: d = 32'h4D41_5401;
`ifdef AXIL_CSR_IRQ_EN
      8'h18: d = {31'h0, m_irqen};
`endif
      default: ;
    endcase
  endtask

  int bvc, aw_err, bresp_err;

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int awd,
                           input int wd, input int bd,
                           input bit done_at_commit,
                           output logic [1:0] resp);
    bit aw_done, w_done, hs_aw, hs_w, got;
    int cyc, bw;
    aw_done = 0; w_done = 0; cyc = 0; bw = 0; got = 0;
    bvc = 0; aw_err = 0; bresp_err = 0; resp = 2'bxx;
    while (!(aw_done && w_done)) begin
      @(negedge ACLK);
      core_done_i = 0;
      AWVALID = !aw_done && cyc >= awd; AWADDR = a;
      WVALID  = !w_done && cyc >= wd;   WDATA = d; WSTRB = s;
      if (aw_done && AWREADY) aw_err++;
      hs_aw = AWVALID && AWREADY;
      hs_w  = WVALID && WREADY;
      if (done_at_commit && (aw_done || hs_aw) && (w_done || hs_w))
        core_done_i = 1;
      @(posedge ACLK);
      aw_done |= hs_aw; w_done |= hs_w; cyc++;
      if (cyc > 200) begin
        chk("wr_addr_data_timeout", 0, 1);
        break;
      end
    end
    forever begin
      @(negedge ACLK);
      AWVALID = 0; WVALID = 0; core_done_i = 0;
      BREADY = bw >= bd;
      if (BVALID) begin
        if (AWREADY) aw_err++;
        if (got && BRESP !== resp) bresp_err++;
        if (!got) resp = BRESP;
        got = 1;
        if (!BREADY) bvc++;
      end
      if (BVALID && BREADY) begin
        @(posedge ACLK);
        break;
      end
      @(posedge ACLK);
      bw++;
      if (bw > 200) begin
        chk("wr_resp_timeout", 0, 1);
        break;
      end
    end
    @(negedge ACLK);
    BREADY = 0;
  endtask

  task automatic axi_read(input logic [7:0] a, input int ard,
                          input int rd, output logic [31:0] d,
                          output logic [1:0] r);
    bit hs, got;
    int cyc, rw;
    cyc = 0; rw = 0; got = 0; d = 'x; r = 'x;
    forever begin
      @(negedge ACLK);
      ARVALID = cyc >= ard; ARADDR = a;
      hs = ARVALID && ARREADY;
      @(posedge ACLK);
      cyc++;
      if (hs) break;
      if (cyc > 200) begin
        chk("rd_addr_timeout", 0, 1);
        break;
      end
    end
    forever begin
      @(negedge ACLK);
      ARVALID = 0;
      RREADY = rw >= rd;
      if (RVALID) begin
        if (got) chk("rdata_stable", RDATA, d);
        d = RDATA; r = RRESP; got = 1;
      end
      if (RVALID && RREADY) begin
        @(posedge ACLK);
        break;
      end
      @(posedge ACLK);
      rw++;
      if (rw > 200) begin
        chk("rd_data_timeout", 0, 1);
        break;
      end
    end
    @(negedge ACLK);
    RREADY = 0;
  endtask

  logic [31:0] rdv, expd;
  logic [1:0]  rr, br, expr;
  int          s0;
  logic [7:0]  tbl [10] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10,
                            8'h14, 8'h18, 8'h1C, 8'h20, 8'hFC};

  initial begin
    model_reset();
    m_start = 0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_awready", AWREADY, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_arready", ARREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_start", start_o, 0);
    chk("rst_dim", dim_o, 0);
    chk("rst_src", src_addr_o, 0);
    chk("rst_dst", dst_addr_o, 0);
    ARST = 0;
    @(negedge ACLK);
    chk("post_rst_awready", AWREADY, 1);
    chk("post_rst_arready", ARREADY, 1);

    axi_read(8'h14, 0, 0, rdv, rr);
    chk("id_data", rdv, 32'h4D41_5401);
    chk("id_resp", rr, 0);
    axi_read(8'h0C, 1, 2, rdv, rr);
    chk("src_init", rdv, 0);

    axi_write(8'h0C, 32'hDEAD_BEEF, 4'b0101, 0, 0, 0, 0, br);
    model_write(8'h0C, 32'hDEAD_BEEF, 4'b0101, 0);
    chk("strb_bresp", br, 0);
    axi_read(8'h0C, 0, 0, rdv, rr);
    chk("strb_read", rdv, 32'h00AD_00EF);
    chk("strb_src_o", src_addr_o, 32'h00AD_00EF);

    s0 = start_cnt;
    axi_write(8'h00, 32'h1, 4'h1, 0, 3, 4, 0, br);
    m_start = start_cnt - s0 + m_start;
    chk("split_bvalid_cycles", bvc, 4);
    chk("split_awready_low", aw_err, 0);
    chk("split_bresp_stable", bresp_err, 0);
    chk("split_bresp", br, 0);
    chk("start_pulse_once", start_cnt - s0, 1);

    core_busy_i = 1;
    s0 = start_cnt;
    axi_write(8'h00, 32'h1, 4'h1, 2, 0, 1, 0, br);
    chk("busy_start_drop", start_cnt - s0, 0);
    chk("busy_start_bresp", br, 0);
    core_busy_i = 0;

    @(negedge ACLK); core_done_i = 1;
    @(negedge ACLK); core_done_i = 0;
    m_done = 1;
    axi_read(8'h04, 0, 0, rdv, rr);
    chk("done_set", rdv, 32'h2);
`ifdef AXIL_CSR_IRQ_EN
    axi_write(8'h18, 32'h1, 4'h1, 0, 0, 0, 0, br);
    m_irqen = 1;
    chk("irq_on", irq_o, 1);
`endif
    axi_write(8'h04, 32'h2, 4'h1, 0, 1, 0, 1, br);
    axi_read(8'h04, 0, 0, rdv, rr);
    chk("done_set_wins", rdv, 32'h2);
    axi_write(8'h04, 32'h2, 4'h1, 0, 0, 0, 0, br);
    m_done = 0;
    axi_read(8'h04, 0, 0, rdv, rr);
    chk("done_cleared", rdv, 32'h0);
`ifdef AXIL_CSR_IRQ_EN
    chk("irq_off", irq_o, 0);
`endif

    axi_write(8'h20, 32'h1234_5678, 4'hF, 0, 0, 0, 0, br);
    chk("unmap_bresp", br, 2'b10);
    axi_read(8'h20, 0, 0, rdv, rr);
    chk("unmap_rdata", rdv, 0);
    chk("unmap_rresp", rr, 2'b10);
    axi_write(8'h18, 32'h1, 4'h1, 0, 0, 0, 0, br);
    model_write(8'h18, 32'h1, 4'h1, 0);
    chk("x18_bresp", br, mapped(8'h18) ? 2'b00 : 2'b10);

    axi_write(8'h08, 32'h0000_00AA, 4'hF, 0, 0, 0, 0, br);
    model_write(8'h08, 32'h0000_00AA, 4'hF, 0);
    @(negedge ACLK);
    AWVALID = 1; AWADDR = 8'h08;
    WVALID = 1; WDATA = 32'h0000_1234; WSTRB = 4'hF;
    ARVALID = 1; ARADDR = 8'h08;
    @(posedge ACLK);
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    chk("raw_rvalid", RVALID, 1);
    chk("raw_old_value", RDATA, 32'h0000_00AA);
    chk("raw_bvalid", BVALID, 1);
    BREADY = 1; RREADY = 1;
    @(posedge ACLK);
    @(negedge ACLK);
    BREADY = 0; RREADY = 0;
    model_write(8'h08, 32'h0000_1234, 4'hF, 0);
    chk("raw_dim_new", dim_o, 16'h1234);

    @(negedge ACLK);
    AWVALID = 1; AWADDR = 8'h10;
    @(posedge ACLK);
    @(negedge ACLK);
    AWVALID = 0; ARST = 1;
    @(posedge ACLK);
    @(negedge ACLK);
    ARST = 0;
    model_reset();
    chk("midrst_bvalid", BVALID, 0);
    chk("midrst_dim", dim_o, 0);
    chk("midrst_src", src_addr_o, 0);
    @(negedge ACLK);
    chk("midrst_awready", AWREADY, 1);
    chk("midrst_wready", WREADY, 1);

    m_start = start_cnt;
    for (int n = 0; n < 80; n++) begin
      logic [7:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      a = tbl[$urandom_range(0, 9)] | 8'($urandom_range(0, 3));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      core_busy_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), 0, br);
        model_write(a, d, s, core_busy_i);
        chk($sformatf("rnd_bresp_%0d", n), br,
            mapped(a) ? 2'b00 : 2'b10);
        chk($sformatf("rnd_start_%0d", n), start_cnt, m_start);
        chk($sformatf("rnd_dim_%0d", n), dim_o, m_dim);
        chk($sformatf("rnd_src_%0d", n), src_addr_o, m_src);
        chk($sformatf("rnd_dst_%0d", n), dst_addr_o, m_dst);
`ifdef AXIL_CSR_IRQ_EN
        chk($sformatf("rnd_irq_%0d", n), irq_o, m_done & m_irqen);
`endif
      end else begin
        axi_read(a, $urandom_range(0, 3), $urandom_range(0, 3), rdv, rr);
        model_read(a, core_busy_i, expd, expr);
        chk($sformatf("rnd_rdata_%0d", n), rdv, expd);
        chk($sformatf("rnd_rresp_%0d", n), rr, expr);
      end
      if ($urandom_range(0, 7) == 0) begin
        @(negedge ACLK); core_done_i = 1;
        @(negedge ACLK); core_done_i = 0;
        m_done = 1;
      end
    end
    core_busy_i = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
